// File: rtl/bpred_pkg.sv
// Shared types and helpers for the fetch-stage branch direction predictor.
// Counter encoding, default geometry and the saturating counter update.
package bpred_pkg;

    localparam int unsigned DEF_IDX_W = 3;
    localparam int unsigned DEF_TAG_W = 12;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    function automatic ctr_t sat_update(ctr_t ctr, logic taken);
        ctr_t res;
        if (taken) begin
            res = (ctr == ST) ? ST : ctr_t'(ctr + 2'd1);
        end else begin
            res = (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/bpred_table.sv
// Tagged 2-bit counter table: two async read ports (lookup and training), one sync write.
// Async active-low clear invalidates every entry and parks counters at WNT.
module bpred_table
    import bpred_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output ctr_t             rd_ctr,
    input  logic [IDX_W-1:0] tr_idx,
    output logic             tr_valid,
    output logic [TAG_W-1:0] tr_tag,
    output ctr_t             tr_ctr,
    input  logic             wr_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  ctr_t             wr_ctr
);

    localparam int unsigned ENTRIES = 2 ** IDX_W;

    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    ctr_t             ctr_q   [ENTRIES];

    always_comb begin
        rd_valid = valid_q[rd_idx];
        rd_tag   = tag_q[rd_idx];
        rd_ctr   = ctr_q[rd_idx];
        tr_valid = valid_q[tr_idx];
        tr_tag   = tag_q[tr_idx];
        tr_ctr   = ctr_q[tr_idx];
    end

    // Writes always go to the training index; a write always leaves the entry valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= WNT;
            end
        end else if (wr_en) begin
            valid_q[tr_idx] <= 1'b1;
            tag_q[tr_idx]   <= wr_tag;
            ctr_q[tr_idx]   <= wr_ctr;
        end
    end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage direction predictor: lookup, next-PC select, decode-time training, mispredict flag.
// Optional perf counters under BPRED_PERF_CNT_EN.
module dynamic_branch_predictor
    import bpred_pkg::*;
#(
    parameter int unsigned IDX_W = DEF_IDX_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PC_curr,
    input  logic [15:0] IF_ID_PC_curr,
    input  logic        IF_ID_pred_taken,
    input  logic        is_branch,
    input  logic        actual_taken,
    input  logic        enable,
    input  logic [15:0] btb_target,
    output logic        predicted_taken,
    output logic [15:0] next_pc,
    output logic        mispredicted
`ifdef BPRED_PERF_CNT_EN
    ,
    output logic [15:0] branch_cnt,
    output logic [15:0] mispred_cnt
`endif
);

    logic [IDX_W-1:0] rd_idx, tr_idx;
    logic [TAG_W-1:0] rd_tag_pc, tr_tag_pc;
    logic             rd_valid, tr_valid;
    logic [TAG_W-1:0] rd_tag, tr_tag;
    ctr_t             rd_ctr, tr_ctr, wr_ctr;
    logic             rd_hit, tr_hit, wr_en;

    // Bit 0 of both PCs is always zero for 16-bit aligned instructions.
    logic unused_pc_lsb;
    assign unused_pc_lsb = PC_curr[0] ^ IF_ID_PC_curr[0];

    always_comb begin
        rd_idx    = PC_curr[IDX_W:1];
        rd_tag_pc = PC_curr[15:IDX_W+1];
        tr_idx    = IF_ID_PC_curr[IDX_W:1];
        tr_tag_pc = IF_ID_PC_curr[15:IDX_W+1];

        rd_hit          = rd_valid && (rd_tag == rd_tag_pc);
        predicted_taken = rd_hit && rd_ctr[1];
        next_pc         = predicted_taken ? btb_target : PC_curr + 16'd2;

        mispredicted = is_branch && (IF_ID_pred_taken != actual_taken);

        tr_hit = tr_valid && (tr_tag == tr_tag_pc);
        wr_en  = enable && is_branch;
        wr_ctr = tr_hit ? sat_update(tr_ctr, actual_taken) : (actual_taken ? WT : WNT);
    end

    bpred_table #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_ctr   (rd_ctr),
        .tr_idx   (tr_idx),
        .tr_valid (tr_valid),
        .tr_tag   (tr_tag),
        .tr_ctr   (tr_ctr),
        .wr_en    (wr_en),
        .wr_tag   (tr_tag_pc),
        .wr_ctr   (wr_ctr)
    );

`ifdef BPRED_PERF_CNT_EN
    logic [15:0] branch_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (enable) begin
            if (is_branch && branch_cnt_q != 16'hFFFF) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
            if (mispredicted && mispred_cnt_q != 16'hFFFF) begin
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
            end
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Self-checking bench for dynamic_branch_predictor against an array-based reference model.
// Perf-counter checks compile in only with BPRED_PERF_CNT_EN.
module tb_dynamic_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] PC_curr = 16'h0;
    logic [15:0] IF_ID_PC_curr = 16'h0;
    logic        IF_ID_pred_taken = 1'b0;
    logic        is_branch = 1'b0;
    logic        actual_taken = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] btb_target = 16'h0;
    logic        predicted_taken;
    logic [15:0] next_pc;
    logic        mispredicted;
`ifdef BPRED_PERF_CNT_EN
    logic [15:0] branch_cnt, mispred_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: per-index valid/tag/counter as plain integers (0..3).
    bit m_valid [8];
    int m_tag   [8];
    int m_ctr   [8];
    int m_bcnt, m_mcnt;

    dynamic_branch_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .PC_curr          (PC_curr),
        .IF_ID_PC_curr    (IF_ID_PC_curr),
        .IF_ID_pred_taken (IF_ID_pred_taken),
        .is_branch        (is_branch),
        .actual_taken     (actual_taken),
        .enable           (enable),
        .btb_target       (btb_target),
        .predicted_taken  (predicted_taken),
        .next_pc          (next_pc),
        .mispredicted     (mispredicted)
`ifdef BPRED_PERF_CNT_EN
        ,
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: timeout reached, required finish before it");
        $fatal(1, "timeout");
    end

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_bcnt = 0;
        m_mcnt = 0;
    endfunction

    function automatic bit model_pred(input logic [15:0] pc);
        int idx = int'(pc[3:1]);
        return m_valid[idx] && (m_tag[idx] == int'(pc[15:4])) && (m_ctr[idx] >= 2);
    endfunction

    function automatic logic [15:0] model_next(input logic [15:0] pc, input logic [15:0] btb);
        return model_pred(pc) ? btb : 16'((int'(pc) + 2) % 65536);
    endfunction

    function automatic void model_train(input logic [15:0] pc, input bit tk, input bit pred);
        int idx = int'(pc[3:1]);
        if (m_valid[idx] && m_tag[idx] == int'(pc[15:4])) begin
            if (tk) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end else begin
            m_valid[idx] = 1;
            m_tag[idx]   = int'(pc[15:4]);
            m_ctr[idx]   = tk ? 2 : 1;
        end
        if (m_bcnt < 65535) m_bcnt++;
        if (pred != tk && m_mcnt < 65535) m_mcnt++;
    endfunction

    task automatic set_in(input logic [15:0] pc, input logic [15:0] ifpc, input logic pred,
                          input logic br, input logic tk, input logic en,
                          input logic [15:0] btb);
        PC_curr = pc;
        IF_ID_PC_curr = ifpc;
        IF_ID_pred_taken = pred;
        is_branch = br;
        actual_taken = tk;
        enable = en;
        btb_target = btb;
    endtask

    // One clock: model follows the DUT's write on the rising edge; returns at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && enable && is_branch) model_train(IF_ID_PC_curr, actual_taken, IF_ID_pred_taken);
        @(negedge clk);
    endtask

    task automatic train(input logic [15:0] pc, input logic tk);
        set_in(16'h0, pc, 1'b0, 1'b1, tk, 1'b1, 16'h0);
        tick();
    endtask

    task automatic test_reset();
        bit ep;
        set_in(16'h0040, 16'h0046, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (predicted_taken !== 1'b0 || next_pc !== 16'h0042) begin
            tests_failed++;
            $display("FAIL reset_lookup: got pt=%0b npc=%h, want pt=0 npc=0042",
                     predicted_taken, next_pc);
        end
        tests_run++;
        if (mispredicted !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mispred: got %0b want 1", mispredicted);
        end
        rst_n = 1'b1;
        @(negedge clk);
        set_in(16'hFFFE, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
        #1;
        tests_run++;
        if (next_pc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL pc_wrap: got %h want 0000", next_pc);
        end
        // Every index must miss after reset.
        for (int i = 0; i < 8; i++) begin
            PC_curr = 16'(16'h0000 + 2 * i);
            #1;
            tests_run++;
            if (predicted_taken !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_entry%0d: got pt=%0b want 0", i, predicted_taken);
            end
        end
        // Write in flight while reset asserts is dropped.
        @(negedge clk);
        set_in(16'h0046, 16'h0046, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0100);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        set_in(16'h0046, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
        #1;
        ep = model_pred(16'h0046);
        tests_run++;
        if (predicted_taken !== ep) begin
            tests_failed++;
            $display("FAIL reset_midtrain: got pt=%0b want %0b", predicted_taken, ep);
        end
        @(negedge clk);
    endtask

    task automatic test_alloc_train();
        train(16'h0046, 1'b1);
        set_in(16'h0046, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
        #1;
        tests_run++;
        if (predicted_taken !== 1'b1 || next_pc !== 16'h0100) begin
            tests_failed++;
            $display("FAIL alloc_taken: got pt=%0b npc=%h, want pt=1 npc=0100",
                     predicted_taken, next_pc);
        end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        bit exp_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        bit tk_seq  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            train(16'h0046, tk_seq[i]);
            set_in(16'h0046, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100);
            #1;
            tests_run++;
            if (predicted_taken !== exp_seq[i] || predicted_taken !== model_pred(16'h0046)) begin
                tests_failed++;
                $display("FAIL saturation step%0d: got pt=%0b want %0b", i, predicted_taken,
                         exp_seq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alias();
        train(16'h0046, 1'b1);
        set_in(16'h0056, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200);
        #1;
        tests_run++;
        if (predicted_taken !== 1'b0 || next_pc !== 16'h0058) begin
            tests_failed++;
            $display("FAIL alias_miss: got pt=%0b npc=%h, want pt=0 npc=0058",
                     predicted_taken, next_pc);
        end
        @(negedge clk);
        train(16'h0056, 1'b1);
        set_in(16'h0056, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0200);
        #1;
        tests_run++;
        if (predicted_taken !== 1'b1) begin
            tests_failed++;
            $display("FAIL alias_replace_new: got pt=%0b want 1", predicted_taken);
        end
        PC_curr = 16'h0046;
        #1;
        tests_run++;
        if (predicted_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL alias_replace_old: got pt=%0b want 0", predicted_taken);
        end
        @(negedge clk);
    endtask

    task automatic test_stall_same_cycle();
        // Entry at index 3 becomes WNT via a not-taken allocation.
        train(16'h0066, 1'b0);
        // Stalled taken trainings must not move it to WT.
        set_in(16'h0066, 16'h0066, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0300);
        #1;
        tests_run++;
        if (mispredicted !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_mispred: got %0b want 1", mispredicted);
        end
        actual_taken = 1'b1;
        repeat (3) tick();
        actual_taken = 1'b1;
        #1;
        tests_run++;
        if (predicted_taken !== 1'b0 || predicted_taken !== model_pred(16'h0066)) begin
            tests_failed++;
            $display("FAIL stall_hold: got pt=%0b want 0", predicted_taken);
        end
        // Same-index read and write: old value before the edge, new value after.
        set_in(16'h0066, 16'h0066, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0300);
        #1;
        tests_run++;
        if (predicted_taken !== 1'b0) begin
            tests_failed++;
            $display("FAIL same_cycle_old: got pt=%0b want 0", predicted_taken);
        end
        tick();
        is_branch = 1'b0;
        #1;
        tests_run++;
        if (predicted_taken !== 1'b1 || next_pc !== 16'h0300) begin
            tests_failed++;
            $display("FAIL same_cycle_new: got pt=%0b npc=%h, want pt=1 npc=0300",
                     predicted_taken, next_pc);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] pc, ifpc, btb, enpc;
        bit pred, br, tk, en, emis;
        for (int n = 0; n < 400; n++) begin
            pc   = {10'h0, 2'($urandom_range(0, 3)), 3'($urandom), 1'b0};
            ifpc = {10'h0, 2'($urandom_range(0, 3)), 3'($urandom), 1'b0};
            if ($urandom_range(0, 3) == 0) ifpc[3:1] = pc[3:1];
            btb  = 16'($urandom);
            pred = 1'($urandom);
            br   = ($urandom_range(0, 3) != 0);
            tk   = 1'($urandom);
            en   = ($urandom_range(0, 4) != 0);
            set_in(pc, ifpc, pred, br, tk, en, btb);
            #1;
            enpc = model_next(pc, btb);
            emis = br && (pred != tk);
            tests_run++;
            if (predicted_taken !== model_pred(pc) || next_pc !== enpc
                || mispredicted !== emis) begin
                tests_failed++;
                $display("FAIL random%0d pc=%h: got pt=%0b npc=%h mp=%0b, want pt=%0b npc=%h mp=%0b",
                         n, pc, predicted_taken, next_pc, mispredicted, model_pred(pc), enpc,
                         emis);
            end
            tick();
        end
    endtask

`ifdef BPRED_PERF_CNT_EN
    task automatic test_perf();
        bit pr [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(16'h0, 16'h0080, pr[i], 1'b1, 1'b0, 1'b1, 16'h0);
            tick();
        end
        is_branch = 1'b0;
        #1;
        tests_run++;
        if (branch_cnt !== 16'd5 || mispred_cnt !== 16'd2 || m_bcnt != 5 || m_mcnt != 2) begin
            tests_failed++;
            $display("FAIL perf_counts: got b=%0d m=%0d, want b=5 m=2", branch_cnt, mispred_cnt);
        end
        set_in(16'h0, 16'h0080, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0);
        while (m_bcnt < 65535) tick();
        is_branch = 1'b0;
        #1;
        tests_run++;
        if (branch_cnt !== 16'hFFFF || mispred_cnt !== 16'(m_mcnt)) begin
            tests_failed++;
            $display("FAIL perf_full: got b=%h m=%h, want b=ffff m=%h", branch_cnt, mispred_cnt,
                     16'(m_mcnt));
        end
        is_branch = 1'b1;
        tick();
        is_branch = 1'b0;
        #1;
        tests_run++;
        if (branch_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL perf_sat: got b=%h want ffff", branch_cnt);
        end
    endtask
`endif

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_alloc_train();
        test_saturation();
        test_alias();
        test_stall_same_cycle();
        test_random();
`ifdef BPRED_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
